// File: rtl/mem_addr_arbiter.sv
// N-source memory address arbiter: one registered memory access at a time, WAIT_CYCLES extra strobe cycles.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority (index 0 highest).
module mem_addr_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned NUM_SRC     = 3,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            req,
    input  logic [NUM_SRC-1:0]            wr_in,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_rd,
    output logic                          mem_wr,
    output logic [NUM_SRC-1:0]            gnt,
    output logic [NUM_SRC-1:0]            done,
    output logic                          busy
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_rd_q, mem_rd_d;
    logic                    mem_wr_q, mem_wr_d;
    logic [NUM_SRC-1:0]      gnt_q, gnt_d;
    logic [NUM_SRC-1:0]      done_q, done_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    int unsigned             win;
    logic                    win_vld;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]        ptr_q, ptr_d;

    // Search starts at ptr and wraps, so the source just served drops to lowest priority.
    always_comb begin : arbitrate
        int unsigned idx;
        idx     = 0;
        win     = 0;
        win_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = (32'(ptr_q) + i) % NUM_SRC;
            if (!win_vld && req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end
`else
    always_comb begin : arbitrate
        win     = 0;
        win_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!win_vld && req[i]) begin
                win     = i;
                win_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin : next_state
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        cnt_d      = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    mem_addr_d = addr_in[win*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wr_d   = wr_in[win];
                    mem_rd_d   = ~wr_in[win];
                    gnt_d      = NUM_SRC'(1) << win;
                    cnt_d      = CNT_W'(WAIT_CYCLES);
                    state_d    = ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    ptr_d      = IDX_W'((win + 1) % NUM_SRC);
`endif
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    gnt_d    = '0;
                    done_d   = gnt_q;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            cnt_q      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign gnt      = gnt_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Randomized and directed bench for mem_addr_arbiter against a transaction-timeline reference model.
module tb_mem_addr_arbiter;

    localparam int AW = 5;
    localparam int NS = 3;
    localparam int WC = 2;

    logic           clk;
    logic           rst;
    logic [NS-1:0]  req;
    logic [NS-1:0]  wr_in;
    logic [NS*AW-1:0] addr_in;
    logic [AW-1:0]  mem_addr;
    logic           mem_rd;
    logic           mem_wr;
    logic [NS-1:0]  gnt;
    logic [NS-1:0]  done;
    logic           busy;

    int n_total = 0;
    int n_bad   = 0;

    // Model: m_t is the position inside the current access (0 = idle,
    // 1..WC+1 = strobe cycles, WC+2 = completion cycle).
    int         m_t   = 0;
    int         m_w   = 0;
    int         m_ptr = 0;
    logic [AW-1:0] m_addr = '0;
    logic       m_wr  = 1'b0;

    mem_addr_arbiter #(
        .ADDR_WIDTH (AW),
        .NUM_SRC    (NS),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr_in   (wr_in),
        .addr_in (addr_in),
        .mem_addr(mem_addr),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [NS-1:0] e_gnt;
        logic [NS-1:0] e_done;
        logic          in_strobe;
        in_strobe = (m_t >= 1) && (m_t <= WC + 1);
        e_gnt     = in_strobe ? NS'(1 << m_w) : '0;
        e_done    = (m_t == WC + 2) ? NS'(1 << m_w) : '0;
        check("gnt",      32'(gnt),      32'(e_gnt));
        check("done",     32'(done),     32'(e_done));
        check("mem_rd",   32'(mem_rd),   32'(in_strobe && !m_wr));
        check("mem_wr",   32'(mem_wr),   32'(in_strobe && m_wr));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("busy",     32'(busy),     32'(m_t != 0));
        check("rd_wr_excl", 32'(mem_rd & mem_wr), 32'(0));
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_w    = 0;
        m_ptr  = 0;
        m_addr = '0;
        m_wr   = 1'b0;
    endtask

    // Advance the model across one rising edge with the inputs currently driven.
    task automatic model_step();
        int pick;
        if (m_t == 0) begin
            pick = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            for (int k = 0; k < NS; k++)
                if (pick < 0 && req[(m_ptr + k) % NS]) pick = (m_ptr + k) % NS;
`else
            for (int k = 0; k < NS; k++)
                if (pick < 0 && req[k]) pick = k;
`endif
            if (pick >= 0) begin
                m_w    = pick;
                m_addr = addr_in[pick*AW +: AW];
                m_wr   = wr_in[pick];
                m_ptr  = (pick + 1) % NS;
                m_t    = 1;
            end
        end else if (m_t < WC + 2) begin
            m_t++;
        end else begin
            m_t = 0;
        end
    endtask

    task automatic drive(input logic [NS-1:0] r, input logic [NS-1:0] w, input logic [NS*AW-1:0] a);
        @(negedge clk);
        check_outputs();
        req     = r;
        wr_in   = w;
        addr_in = a;
        model_step();
    endtask

    task automatic run_n(input int n, input logic [NS-1:0] r, input logic [NS-1:0] w,
                         input logic [NS*AW-1:0] a);
        for (int i = 0; i < n; i++) drive(r, w, a);
    endtask

    // Asynchronous reset shortly after a rising edge; outputs must clear without waiting for a clock.
    task automatic reset_mid();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst     = 1'b0;
        req     = '0;
        wr_in   = '0;
        addr_in = '0;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        wr_in   = '0;
        addr_in = '0;
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // single read from source 1
        run_n(WC + 3, 3'b010, 3'b000, {5'h00, 5'h0A, 5'h00});
        run_n(2, 3'b000, 3'b000, {5'h00, 5'h0A, 5'h00});
        // write from source 2
        run_n(WC + 3, 3'b100, 3'b100, {5'h1F, 5'h00, 5'h00});
        run_n(2, 3'b000, 3'b000, '0);
        // contention held
        run_n(4 * (WC + 3), 3'b111, 3'b000, {5'h03, 5'h02, 5'h01});
        run_n(2, 3'b000, 3'b000, '0);
        // inputs change mid-access
        drive(3'b001, 3'b000, {5'h00, 5'h00, 5'h05});
        run_n(WC + 3, 3'b000, 3'b001, {5'h00, 5'h00, 5'h06});
        // reset in the second strobe cycle, then a normal read
        drive(3'b001, 3'b000, {5'h00, 5'h00, 5'h07});
        drive(3'b001, 3'b000, {5'h00, 5'h00, 5'h07});
        reset_mid();
        run_n(WC + 3, 3'b001, 3'b000, {5'h00, 5'h00, 5'h09});
        run_n(2, 3'b000, 3'b000, '0);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                reset_mid();
            end else begin
                drive(($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom),
                      3'($urandom), 15'($urandom));
            end
        end
        @(negedge clk);
        check_outputs();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
